// File: rtl/pt_dec.sv
// PT2262-style OOK frame decoder: recovers a 24-bit word (12 trits) from the serial pulse stream.
// Optional PT_DEC_REPEAT_CHECK_EN: data/valid update only when a good frame repeats the previous one.
module pt_dec #(
    parameter int unsigned CLK_PER_A = 4800,
    parameter int unsigned CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] data,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int unsigned NBITS = 24;
    localparam int unsigned IDX_W = 5;

    localparam logic [CNT_W-1:0] T_SHORT  = CNT_W'(2 * CLK_PER_A);
    localparam logic [CNT_W-1:0] T_LONG   = CNT_W'(8 * CLK_PER_A);
    localparam logic [CNT_W-1:0] T_OVER   = CNT_W'(16 * CLK_PER_A);
    localparam logic [CNT_W-1:0] T_GAP    = CNT_W'(64 * CLK_PER_A);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS);

    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        BIT_HI,
        BIT_LO,
        DONE,
        ERR
    } state_t;

    state_t             state_q;
    logic               sync1_q;
    logic               sync2_q;
    logic               lvl_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NBITS-1:0]   shift_q;
    logic               hi_long_q;
    logic [NBITS-1:0]   data_q;
    logic               valid_q;
    logic               err_q;
    logic               busy_q;

`ifdef PT_DEC_REPEAT_CHECK_EN
    logic [NBITS-1:0]   cand_q;
    logic               cand_v_q;
`endif

    logic rise_c;
    logic fall_c;
    logic low_c;
    logic last_c;
    logic cls_glitch_c;
    logic cls_short_c;
    logic cls_long_c;
    logic cls_over_c;
    logic pair_ok_c;

    // Edges of the synchronized level; cnt_q is the duration of the level just ended
    assign rise_c = sync2_q & ~lvl_q;
    assign fall_c = ~sync2_q & lvl_q;
    assign low_c  = ~sync2_q & ~lvl_q;
    assign last_c = (idx_q == IDX_LAST);

    assign cls_glitch_c = (cnt_q < T_SHORT);
    assign cls_short_c  = ~cls_glitch_c & (cnt_q < T_LONG);
    assign cls_long_c   = (cnt_q >= T_LONG) & (cnt_q < T_OVER);
    assign cls_over_c   = (cnt_q >= T_OVER);
    assign pair_ok_c    = hi_long_q ? cls_short_c : cls_long_c;

    // Input synchronizer and saturating level-duration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            lvl_q   <= sync2_q;
            if (sync2_q != lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame FSM with registered strobes and output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            shift_q   <= '0;
            hi_long_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PT_DEC_REPEAT_CHECK_EN
            cand_q    <= '0;
            cand_v_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef PT_DEC_REPEAT_CHECK_EN
            if (err_q) begin
                cand_v_q <= 1'b0;
            end
`endif
            case (state_q)
                HUNT: begin
                    if (low_c && (cnt_q >= T_GAP)) begin
                        state_q <= IDLE;
                    end
                end

                IDLE: begin
                    if (rise_c) begin
                        state_q <= BIT_HI;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                BIT_HI: begin
                    if (fall_c) begin
                        if (cls_glitch_c || cls_over_c || (last_c && !cls_short_c)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            hi_long_q <= cls_long_c;
                            state_q   <= BIT_LO;
                        end
                    end
                end

                BIT_LO: begin
                    if (last_c) begin
                        if (rise_c) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == T_GAP) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
`ifdef PT_DEC_REPEAT_CHECK_EN
                            if (cand_v_q && (cand_q == shift_q)) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                cand_q   <= shift_q;
                                cand_v_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end
                    end else if (rise_c) begin
                        if (pair_ok_c) begin
                            shift_q <= {shift_q[NBITS-2:0], hi_long_q};
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= BIT_HI;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if ((idx_q == '0) && cls_over_c) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cnt_q >= T_GAP) begin
                        // Truncated frame: the long low already serves as the next sync
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end

                DONE: begin
                    if (rise_c) begin
                        state_q <= BIT_HI;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                ERR: begin
                    state_q <= HUNT;
                end

                default: begin
                    state_q <= HUNT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_pt_dec.sv
// Bench for pt_dec: directed OOK frames, expected valid/err events queued and checked by a monitor.
module tb_pt_dec;

    localparam int unsigned A = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        din   = 1'b0;
    logic [23:0] data;
    logic        valid;
    logic        err;
    logic        busy;

    int checks        = 0;
    int failures      = 0;
    int cyc           = 0;
    int sync_fall_cyc = 0;

    typedef struct {
        logic        is_err;
        logic [23:0] d;
    } ev_t;

    ev_t         sb[$];
    logic [23:0] last_data = '0;
`ifdef PT_DEC_REPEAT_CHECK_EN
    logic [23:0] cand   = '0;
    logic        cand_v = 1'b0;
`endif

    pt_dec #(.CLK_PER_A(A), .CNT_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .data  (data),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input logic is_err, input logic [23:0] d);
        ev_t e;
        e.is_err = is_err;
        e.d      = d;
        sb.push_back(e);
    endfunction

    // Expected response of a well-formed frame
    function automatic void exp_good(input logic [23:0] w);
`ifdef PT_DEC_REPEAT_CHECK_EN
        if (cand_v && (cand == w)) begin
            push_ev(1'b0, w);
            last_data = w;
        end else begin
            cand   = w;
            cand_v = 1'b1;
        end
`else
        push_ev(1'b0, w);
        last_data = w;
`endif
    endfunction

    function automatic void exp_err();
        push_ev(1'b1, last_data);
`ifdef PT_DEC_REPEAT_CHECK_EN
        cand_v = 1'b0;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half_bit(input logic b);
        din = 1'b1;
        wait_cyc(b ? 12 * A : 4 * A);
        din = 1'b0;
        wait_cyc(b ? 4 * A : 12 * A);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            half_bit(w[23 - i]);
        end
    endtask

    task automatic send_sync();
        din = 1'b1;
        wait_cyc(4 * A);
        din = 1'b0;
        sync_fall_cyc = cyc;
        wait_cyc(124 * A);
    endtask

    task automatic send_frame(input logic [23:0] w);
        send_bits(w, 0, 23);
        send_sync();
    endtask

    // Monitor: every valid/err strobe must match the head of the expected queue
    always @(negedge clk) begin
        ev_t e;
        int  lat;
        if (rst_n && (valid || err)) begin
            check("valid_err_exclusive", 32'(valid & err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_event", 32'({err, valid}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_is_err", 32'(err), 32'(e.is_err));
                check("event_data", 32'(data), 32'(e.d));
                if (valid) begin
                    // 64a gap plus the two synchronizer flops and the edge/state registers
                    lat = cyc - sync_fall_cyc;
                    checks++;
                    if (lat < int'(64 * A + 2) || lat > int'(64 * A + 4)) begin
                        failures++;
                        $display("FAIL valid_latency: got %0d cycles expected %0d..%0d",
                                 lat, 64 * A + 2, 64 * A + 4);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] w;

        rst_n = 1'b0;
        din   = 1'b0;
        wait_cyc(4);
        check("reset_data", 32'(data), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_cyc(140 * A);

        // Single frame after idle preamble
        w = 24'hA5_3CF0;
        exp_good(w);
        send_bits(w, 0, 11);
        check("busy_mid_frame", 32'(busy), 32'd1);
        send_bits(w, 12, 23);
        send_sync();
        check("busy_after_frame", 32'(busy), 32'd0);
        check("data_after_frame", 32'(data), 32'(last_data));

        // Back-to-back extremes
        exp_good(24'h000000);
        send_frame(24'h000000);
        exp_good(24'hFFFFFF);
        send_frame(24'hFFFFFF);

        // Tenth half-bit with short high and short low
        w = 24'h5A_5A5A;
        exp_err();
        send_bits(w, 0, 8);
        din = 1'b1;
        wait_cyc(4 * A);
        din = 1'b0;
        wait_cyc(4 * A);
        send_bits(w, 10, 23);
        send_sync();
        check("data_held_after_err", 32'(data), 32'(last_data));
        exp_good(24'hC3_A50F);
        send_frame(24'hC3_A50F);

        // Truncated frame: 20 half-bits then a long low
        exp_err();
        send_bits(24'h77_7777, 0, 19);
        wait_cyc(124 * A);
        exp_good(24'h12_3456);
        send_frame(24'h12_3456);

        // One-clock glitch inside the low of a zero half-bit
        exp_err();
        half_bit(1'b0);
        half_bit(1'b0);
        half_bit(1'b0);
        din = 1'b1;
        wait_cyc(4 * A);
        din = 1'b0;
        wait_cyc(5 * A);
        din = 1'b1;
        wait_cyc(1);
        din = 1'b0;
        wait_cyc(140 * A);

        // Reset pulsed in the middle of a frame
        w = 24'h5A_5A5A;
        exp_good(24'h13_579B);
        sb.delete();
        send_bits(w, 0, 9);
        din = 1'b1;
        wait_cyc(2 * A);
        check("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_data", 32'(data), 32'd0);
        check("async_reset_valid", 32'(valid), 32'd0);
        check("async_reset_err", 32'(err), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        last_data = '0;
`ifdef PT_DEC_REPEAT_CHECK_EN
        cand_v = 1'b0;
`endif
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2 * A);
        din = 1'b0;
        wait_cyc(12 * A);
        send_bits(w, 11, 23);
        send_sync();
        check("data_after_partial_frame", 32'(data), 32'd0);
        exp_good(24'h13_579B);
        send_frame(24'h13_579B);

        // Repeated-frame sequence
        exp_good(24'hAB_CDEF);
        send_frame(24'hAB_CDEF);
        exp_good(24'hAB_CDEF);
        send_frame(24'hAB_CDEF);
        exp_good(24'h12_3456);
        send_frame(24'h12_3456);
        exp_good(24'h12_3456);
        send_frame(24'h12_3456);

        wait_cyc(20);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
